// File: rtl/i2s_tx_fifo.sv
// Stereo sample FIFO feeding an I2S / left-justified DAC serializer.
// BCLK and LRCLK are oversampled on CLK; all shifting happens on synced BCLK falls.
module i2s_tx_fifo #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               CLK,
  input  logic                               RESET_N,
  input  logic                               BCLK,
  input  logic                               LRCLK,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DATA_W-1:0]                  in_left,
  input  logic [DATA_W-1:0]                  in_right,
  input  logic                               mode_i2s,
  input  logic                               mute,
  output logic                               DACDAT,
  output logic                               underrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {ALIGN, LEFT, RIGHT} state_t;

  state_t state_q, state_d;

  logic [1:0] rst_sync;
  logic       rst_n;
  logic [1:0] bclk_sync;
  logic [1:0] lr_sync;
  logic       bclk_prev;
  logic       lr_cur;
  logic       bclk_fall;
  logic       left_start;
  logic       right_start;

  logic [DATA_W-1:0] mem_l [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level;
  logic              fifo_empty;
  logic              push, pop, starve;

  logic              load_left, load_right;
  logic [DATA_W-1:0] left_word, right_word, slot_word;
  logic              slot_i2s;
  logic [DATA_W-1:0] right_hold;
  logic              frame_i2s;
  logic [DATA_W-1:0] shift_reg;
  logic [CNT_W-1:0]  bit_cnt;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // lr_cur idles high so a reset released inside a left slot cannot fake a left start
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      bclk_sync <= '0;
      lr_sync   <= '0;
      bclk_prev <= 1'b0;
      lr_cur    <= 1'b1;
    end else begin
      bclk_sync <= {bclk_sync[0], BCLK};
      lr_sync   <= {lr_sync[0], LRCLK};
      bclk_prev <= bclk_sync[1];
      if (bclk_fall) lr_cur <= lr_sync[1];
    end
  end

  assign bclk_fall   = bclk_prev & ~bclk_sync[1];
  assign left_start  = bclk_fall & ~lr_cur &  lr_sync[1];
  assign right_start = bclk_fall &  lr_cur & ~lr_sync[1];

  assign in_ready   = (level != LVL_W'(FIFO_DEPTH));
  assign fifo_empty = (level == '0);
  assign push       = in_valid & in_ready;
  assign pop        = load_left & ~fifo_empty;
  assign starve     = load_left &  fifo_empty;
  assign fifo_level = level;

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_l[wr_ptr] <= in_left;
      mem_r[wr_ptr] <= in_right;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state_q <= ALIGN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    load_left  = 1'b0;
    load_right = 1'b0;
    unique case (state_q)
      ALIGN: if (left_start) begin
        state_d   = LEFT;
        load_left = 1'b1;
      end
      LEFT: if (right_start) begin
        state_d    = RIGHT;
        load_right = 1'b1;
      end
      RIGHT: if (left_start) begin
        state_d   = LEFT;
        load_left = 1'b1;
      end
      default: state_d = ALIGN;
    endcase
  end

  // Mute is applied to both words at the left start, so it holds for the whole frame
  assign left_word  = (mute | fifo_empty) ? '0 : mem_l[rd_ptr];
  assign right_word = (mute | fifo_empty) ? '0 : mem_r[rd_ptr];
  assign slot_word  = load_left ? left_word : right_hold;
  assign slot_i2s   = load_left ? mode_i2s  : frame_i2s;

  // bit_cnt counts bits already driven; left-justified drives the MSB at load
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      right_hold <= '0;
      frame_i2s  <= 1'b0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      DACDAT     <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      underrun <= starve;
      if (load_left) begin
        right_hold <= right_word;
        frame_i2s  <= mode_i2s;
      end
      if (load_left || load_right) begin
        if (slot_i2s) begin
          shift_reg <= slot_word;
          bit_cnt   <= '0;
          DACDAT    <= 1'b0;
        end else begin
          shift_reg <= slot_word << 1;
          bit_cnt   <= CNT_W'(1);
          DACDAT    <= slot_word[DATA_W-1];
        end
      end else if (bclk_fall && state_q != ALIGN) begin
        if (bit_cnt < CNT_W'(DATA_W)) begin
          DACDAT    <= shift_reg[DATA_W-1];
          shift_reg <= shift_reg << 1;
          bit_cnt   <= bit_cnt + CNT_W'(1);
        end else begin
          DACDAT <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_fifo.sv
// Scoreboard bench for i2s_tx_fifo: bench-driven BCLK/LRCLK, 32 BCLK per slot.
module tb_i2s_tx_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } pair_t;

  logic          CLK      = 1'b0;
  logic          RESET_N  = 1'b0;
  logic          BCLK     = 1'b1;
  logic          LRCLK    = 1'b0;
  logic          in_valid = 1'b0;
  logic          mode_i2s = 1'b0;
  logic          mute     = 1'b0;
  logic [DW-1:0] in_left  = '0;
  logic [DW-1:0] in_right = '0;
  logic          in_ready;
  logic          DACDAT;
  logic          underrun;
  logic [LW-1:0] fifo_level;

  int    n_cmp     = 0;
  int    n_bad     = 0;
  int    acc_cnt   = 0;
  int    under_cnt = 0;
  int    exp_under = 0;
  int    pend_mark = 0;
  int    mute_at   = -1;
  bit    pend      = 0;
  bit    hook_n2   = 0;
  pair_t hook_pair;
  pair_t sb_q[$];

  always #5 CLK = ~CLK;

  i2s_tx_fifo #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .BCLK(BCLK), .LRCLK(LRCLK),
    .in_valid(in_valid), .in_ready(in_ready), .in_left(in_left), .in_right(in_right),
    .mode_i2s(mode_i2s), .mute(mute), .DACDAT(DACDAT), .underrun(underrun),
    .fifo_level(fifo_level)
  );

  // Accepted pairs enter the scoreboard; underrun high cycles are counted
  always @(posedge CLK) begin
    if (in_valid && in_ready) begin
      sb_q.push_back({in_left, in_right});
      acc_cnt++;
    end
    if (underrun) under_cnt++;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  function automatic logic slot_bit(input logic [DW-1:0] w, input logic i2s, input int j);
    int k;
    k = i2s ? j - 1 : j;
    if (k < 0 || k >= DW) return 1'b0;
    return w[DW-1-k];
  endfunction

  task automatic pend_poll();
    if (pend && acc_cnt != pend_mark) begin
      in_valid = 1'b0;
      pend     = 0;
    end
  endtask

  task automatic bclk_period(input logic lr, input logic exp_bit, input string tag);
    @(negedge CLK);
    BCLK  = 1'b0;
    LRCLK = lr;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (hook_n2 && i == 1) begin
        in_left  = hook_pair.l;
        in_right = hook_pair.r;
        in_valid = 1'b1;
      end
      if (hook_n2 && i == 2) begin
        in_valid = 1'b0;
        hook_n2  = 0;
      end
      pend_poll();
    end
    BCLK = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      pend_poll();
    end
    n_cmp++;
    if (DACDAT !== exp_bit) begin
      n_bad++;
      $display("FAIL %s: DACDAT=%b required %b", tag, DACDAT, exp_bit);
    end
  endtask

  task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
    int mark;
    mark = acc_cnt;
    @(negedge CLK);
    in_left  = l;
    in_right = r;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && acc_cnt == mark; i++) @(negedge CLK);
    in_valid = 1'b0;
    n_cmp++;
    if (acc_cnt == mark) begin
      n_bad++;
      $display("FAIL push_accept: accepted=0 required 1");
    end
  endtask

  task automatic check_level(input string tag, input int exp);
    n_cmp++;
    if (fifo_level !== LW'(exp)) begin
      n_bad++;
      $display("FAIL %s: fifo_level=%0d required %0d", tag, fifo_level, exp);
    end
  endtask

  task automatic run_frame(input string name);
    pair_t p;
    logic  i2s;
    i2s = mode_i2s;
    if (sb_q.size() > 0) p = sb_q.pop_front();
    else begin
      p = '0;
      exp_under++;
    end
    if (mute) p = '0;
    for (int j = 0; j < 32; j++) begin
      bclk_period(1'b1, slot_bit(p.l, i2s, j), $sformatf("%s_left_bit%0d", name, j));
      if (j == 0) begin
        check_level({name, "_level_after_pop"}, sb_q.size());
        n_cmp++;
        if (in_ready !== (sb_q.size() != DEPTH)) begin
          n_bad++;
          $display("FAIL %s_in_ready: in_ready=%b required %b", name, in_ready, sb_q.size() != DEPTH);
        end
      end
      if (j == mute_at) mute = 1'b1;
    end
    for (int j = 0; j < 32; j++)
      bclk_period(1'b0, slot_bit(p.r, i2s, j), $sformatf("%s_right_bit%0d", name, j));
    n_cmp++;
    if (under_cnt !== exp_under) begin
      n_bad++;
      $display("FAIL %s_underrun_cycles: count=%0d required %0d", name, under_cnt, exp_under);
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    n_cmp += 4;
    if (DACDAT !== 1'b0)   begin n_bad++; $display("FAIL reset_dacdat: got %b required 0", DACDAT); end
    if (underrun !== 1'b0) begin n_bad++; $display("FAIL reset_underrun: got %b required 0", underrun); end
    if (fifo_level !== '0) begin n_bad++; $display("FAIL reset_level: got %0d required 0", fifo_level); end
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    RESET_N = 1'b1;
    repeat (4) @(negedge CLK);
    for (int j = 0; j < 3; j++) bclk_period(1'b0, 1'b0, $sformatf("align_right_bit%0d", j));
    n_cmp++;
    if (under_cnt !== 0) begin n_bad++; $display("FAIL align_no_underrun: count=%0d required 0", under_cnt); end
  endtask

  task automatic test_left_justified();
    push_pair(16'hA5C3, 16'h0F0F);
    check_level("lj_level_before", 1);
    run_frame("lj");
  endtask

  task automatic test_i2s();
    mode_i2s = 1'b1;
    push_pair(16'hA5C3, 16'h0F0F);
    run_frame("i2s");
    mode_i2s = 1'b0;
  endtask

  task automatic test_back_to_back();
    int start;
    start = acc_cnt;
    @(negedge CLK);
    for (int k = 0; k < 4; k++) begin
      in_left  = 16'h1100 + 16'(k);
      in_right = 16'h2200 + 16'(k);
      in_valid = 1'b1;
      @(negedge CLK);
    end
    in_left  = 16'h3300;
    in_right = 16'h4400;
    n_cmp += 2;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_full_ready: got %b required 0", in_ready); end
    if (acc_cnt - start !== 4) begin n_bad++; $display("FAIL b2b_accepted: got %0d required 4", acc_cnt - start); end
    check_level("b2b_level_full", 4);
    repeat (5) @(negedge CLK);
    n_cmp++;
    if (acc_cnt - start !== 4) begin n_bad++; $display("FAIL b2b_fifth_held: accepted=%0d required 4", acc_cnt - start); end
    pend_mark = acc_cnt;
    pend      = 1;
    for (int f = 0; f < 5; f++) run_frame($sformatf("b2b_f%0d", f));
    n_cmp++;
    if (acc_cnt - start !== 5) begin n_bad++; $display("FAIL b2b_fifth_taken: accepted=%0d required 5", acc_cnt - start); end
    pend     = 0;
    in_valid = 1'b0;
  endtask

  task automatic test_underrun();
    int mark;
    mark      = acc_cnt;
    hook_pair = {16'h1357, 16'h2468};
    hook_n2   = 1;
    run_frame("under_empty");
    n_cmp++;
    if (acc_cnt - mark !== 1) begin n_bad++; $display("FAIL under_same_cycle_push: accepted=%0d required 1", acc_cnt - mark); end
    run_frame("under_next");
  endtask

  task automatic test_mute();
    push_pair(16'h1234, 16'hABCD);
    push_pair(16'h7FFF, 16'h8000);
    mute_at = 5;
    run_frame("mute_cur");
    mute_at = -1;
    check_level("mute_level_before", 1);
    run_frame("mute_next");
    mute = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    pair_t p;
    push_pair(16'hA5C3, 16'h0F0F);
    p = sb_q.pop_front();
    for (int j = 0; j < 6; j++) bclk_period(1'b1, slot_bit(p.l, 1'b0, j), $sformatf("rst_pre_bit%0d", j));
    #2 RESET_N = 1'b0;
    #1;
    n_cmp += 3;
    if (DACDAT !== 1'b0)   begin n_bad++; $display("FAIL rst_mid_dacdat: got %b required 0", DACDAT); end
    if (fifo_level !== '0) begin n_bad++; $display("FAIL rst_mid_level: got %0d required 0", fifo_level); end
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_in_ready: got %b required 1", in_ready); end
    sb_q.delete();
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    for (int j = 6; j < 32; j++) bclk_period(1'b1, 1'b0, $sformatf("rst_left_tail_bit%0d", j));
    for (int j = 0; j < 32; j++) bclk_period(1'b0, 1'b0, $sformatf("rst_right_bit%0d", j));
    n_cmp++;
    if (under_cnt !== exp_under) begin n_bad++; $display("FAIL rst_no_underrun: count=%0d required %0d", under_cnt, exp_under); end
    push_pair(16'hC3A5, 16'hF00F);
    run_frame("rst_first");
  endtask

  initial begin
    test_reset();
    test_left_justified();
    test_i2s();
    test_back_to_back();
    test_underrun();
    test_mute();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2s_tx_fifo.md
Name: i2s_tx_fifo

Overview:
Parametrised successor to the codec DAC serializer. Runs entirely on the system clock CLK and oversamples externally generated BCLK/LRCLK. Buffers stereo sample pairs in a small FIFO with a valid/ready handshake, and serializes them MSB-first onto DACDAT. Supports I2S (one-BCLK delay) and left-justified framing, mute, and underrun reporting. Sits between the effects pipeline output and the codec DAC pin.

Parameters:
DATA_W, 16, sample width in bits (2..32).
FIFO_DEPTH, 4, stereo pair entries (power of 2, >=2).

Ports:
CLK  in  1  system clock; must be >=8x BCLK frequency.
RESET_N  in  1  asynchronous active-low reset.
BCLK  in  1  codec bit clock, asynchronous to CLK.
LRCLK  in  1  codec frame clock, asynchronous; 1 = left slot.
in_valid  in  1  sample pair offered.
in_ready  out  1  FIFO can accept a pair.
in_left  in  DATA_W  signed left sample.
in_right  in  DATA_W  signed right sample.
mode_i2s  in  1  1 = I2S framing, 0 = left-justified.
mute  in  1  force zero data; FIFO still drains.
DACDAT  out  1  serial data to codec.
underrun  out  1  one-CLK pulse when a left slot starts with the FIFO empty.
fifo_level  out  $clog2(FIFO_DEPTH+1)  occupied entries.

Behaviour:
- Reset (async assert, sync release): DACDAT=0, underrun=0, fifo_level=0, in_ready=1, FIFO pointers 0, state=ALIGN, synchronizers cleared.
- BCLK and LRCLK each pass through a 2-FF synchronizer. bclk_fall is a one-CLK strobe on a synced 1->0 transition. All serializer activity occurs only on bclk_fall cycles.
- On each bclk_fall, synced LRCLK is sampled into lr_cur, and lr_prev<=lr_cur.
  - Left start: lr_prev=0, lr_cur=1.
  - Right start: lr_prev=1, lr_cur=0.
- FIFO:
  - Push when in_valid && in_ready.
  - in_ready = (level != FIFO_DEPTH). This is combinational from level only, so a push is not accepted while full even if a pop happens the same cycle.
  - Pop occurs only at a left start in LEFT/RIGHT/ALIGN->LEFT.
  - Simultaneous push and pop with level>0: level unchanged.
  - Pop attempted with level=0: no pop, underrun pulses, and the pair is treated as zeros. A push in that same cycle is still stored.
- State machine:
  - ALIGN: DACDAT=0; right starts are ignored with no underrun. On the first left start, go to LEFT and perform a pop/load.
  - LEFT: on a right start, load the held right word; go to RIGHT.
  - RIGHT: on a left start, pop, load the left word, latch mode_i2s and mute for the whole frame; go to LEFT.
  - A left start in LEFT or a right start in RIGHT cannot occur by construction. LRCLK glitches are handled simply by following lr_prev/lr_cur edges.
- Slot load: shift_reg <= word (zero if mute or underrun); bit_cnt <= 0.
  - Left-justified: DACDAT <= word MSB on the same bclk_fall as the slot start; the remaining bits follow on subsequent falls.
  - I2S: DACDAT <= 0 on the slot-start fall; MSB on the next fall.
  - After DATA_W bits have been driven, DACDAT=0 until the next slot start. bit_cnt saturates at DATA_W.
- Latency: sample pair accepted -> earliest MSB on DACDAT is at the next left start (+1 BCLK in I2S mode). DACDAT changes exactly 1 CLK after the bclk_fall strobe.
- mode_i2s/mute changes mid-frame take effect at the next left start only.
- Short slot (edge arrives before DATA_W bits are sent): truncate, then load the new slot.
- Reset asserted mid-frame: all state is lost immediately; the block restarts in ALIGN.

Test Plan:
- Reset then push (L=16'hA5C3, R=16'h0F0F), left-justified, 32 BCLK per slot -> left slot DACDAT = 1010010111000011 then 16 zeros; right slot = 0000111100001111 then zeros; fifo_level 1->0 at left start.
- Same pair with mode_i2s=1 -> each slot begins with one 0 bit, then the 16 data bits, then zeros.
- Push 5 pairs back-to-back with DEPTH=4 and no BCLK -> in_ready drops after the 4th; fifo_level=4; the 5th is held off until the first left-start pop.
- Empty FIFO at a left start -> underrun high exactly 1 CLK; both slots output all zeros; a pair pushed in the same cycle is output in the next frame.
- mute=1 asserted mid-left-slot with (L=16'h7FFF, R=16'h8000) queued -> current frame unaffected; next frame all zeros while fifo_level still decrements.
- Reset pulsed mid-left-slot, then a right start -> DACDAT stays 0 with no underrun until the first left start; the first queued pair is output intact.
